// File: rtl/rx_deframer_if.sv
// rtl/rx_deframer_if.sv - bit-stream input and decoded-frame output bundle for rx_deframer
interface rx_deframer_if;
    logic        data_in;
    logic        data_valid;
    logic [5:0]  n_pad;
    logic [3:0]  rate;
    logic [11:0] length;
    logic        hdr_ok;
    logic        hdr_err;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        frame_done;
    logic        busy;

    modport master (
        output data_in, data_valid, n_pad,
        input  rate, length, hdr_ok, hdr_err, byte_out, byte_valid, frame_done, busy
    );

    modport slave (
        input  data_in, data_valid, n_pad,
        output rate, length, hdr_ok, hdr_err, byte_out, byte_valid, frame_done, busy
    );
endinterface

// File: rtl/rx_deframer.sv
// rtl/rx_deframer.sv - receive deframer: SIGNAL check, x^7+x^4+1 descrambling, PSDU byte packing
// Optional build macro RX_SEED_RECOVERY_EN: load the descrambler from the first 7 SERVICE bits.
module rx_deframer #(
    parameter int         HDR_BITS     = 36,
    parameter int         SERVICE_BITS = 16,
    parameter logic [6:0] SCR_SEED     = 7'b1011011
) (
    input  logic         Clk,
    input  logic         reset,
    rx_deframer_if.slave bus
);
    localparam int HW = $clog2(HDR_BITS);
    localparam int SW = $clog2(SERVICE_BITS);

    localparam logic [1:0] ST_HEADER  = 2'd0;
    localparam logic [1:0] ST_SERVICE = 2'd1;
    localparam logic [1:0] ST_PSDU    = 2'd2;
    localparam logic [1:0] ST_TAIL    = 2'd3;

    logic [1:0]    state_q,      state_d;
    logic [23:0]   sig_q,        sig_d;
    logic [HW-1:0] hdr_cnt_q,    hdr_cnt_d;
    logic [SW-1:0] svc_cnt_q,    svc_cnt_d;
    logic [14:0]   psdu_cnt_q,   psdu_cnt_d;
    logic [6:0]    tail_cnt_q,   tail_cnt_d;
    logic [6:0]    tail_len_q,   tail_len_d;
    logic [6:0]    lfsr_q,       lfsr_d;
    logic [7:0]    byte_asm_q,   byte_asm_d;
    logic [3:0]    rate_q,       rate_d;
    logic [11:0]   length_q,     length_d;
    logic          hdr_ok_q,     hdr_ok_d;
    logic          hdr_err_q,    hdr_err_d;
    logic [7:0]    byte_out_q,   byte_out_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_done_q, frame_done_d;

    logic          lfsr_fb;
    logic [6:0]    lfsr_step;
    logic          desc_bit;
    logic [23:0]   sig_shift;
    logic          par_bad;
    logic          hdr_last;
    logic          svc_last;
    logic          psdu_last;
    logic          tail_last;
    logic          sig_unused;

    assign lfsr_fb    = lfsr_q[6] ^ lfsr_q[3];
    assign lfsr_step  = {lfsr_q[5:0], lfsr_fb};
    assign desc_bit   = bus.data_in ^ lfsr_fb;
    assign sig_shift  = {sig_q[22:0], bus.data_in};
    // Even parity covers rate, reserved, length and the parity bit itself.
    assign par_bad    = ^sig_shift[23:6];
    assign hdr_last   = (hdr_cnt_q == HW'(HDR_BITS - 1));
    assign svc_last   = (svc_cnt_q == SW'(SERVICE_BITS - 1));
    assign psdu_last  = (psdu_cnt_q == ({length_q, 3'b000} - 15'd1));
    assign tail_last  = (tail_cnt_q == (tail_len_q - 7'd1));
    assign sig_unused = ^{sig_q[23], sig_shift[5:0]};

    always_comb begin
        state_d      = state_q;
        sig_d        = sig_q;
        hdr_cnt_d    = hdr_cnt_q;
        svc_cnt_d    = svc_cnt_q;
        psdu_cnt_d   = psdu_cnt_q;
        tail_cnt_d   = tail_cnt_q;
        tail_len_d   = tail_len_q;
        lfsr_d       = lfsr_q;
        byte_asm_d   = byte_asm_q;
        rate_d       = rate_q;
        length_d     = length_q;
        hdr_ok_d     = 1'b0;
        hdr_err_d    = 1'b0;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        frame_done_d = 1'b0;

        if (bus.data_valid) begin
            case (state_q)
                ST_HEADER: begin
                    sig_d = sig_shift;
                    if (hdr_last) begin
                        hdr_cnt_d = '0;
                        if (!par_bad && sig_shift[23]) begin
                            hdr_ok_d  = 1'b1;
                            rate_d    = sig_shift[23:20];
                            length_d  = sig_shift[18:7];
                            lfsr_d    = SCR_SEED;
                            svc_cnt_d = '0;
                            state_d   = ST_SERVICE;
                        end else begin
                            hdr_err_d = 1'b1;
                        end
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 1'b1;
                    end
                end

                ST_SERVICE: begin
                    lfsr_d = lfsr_step;
`ifdef RX_SEED_RECOVERY_EN
                    // SERVICE is all zeros at the transmitter, so the line bits are its keystream.
                    if (svc_cnt_q < SW'(7)) begin
                        lfsr_d = {lfsr_q[5:0], bus.data_in};
                    end
`endif
                    svc_cnt_d = svc_cnt_q + 1'b1;
                    if (svc_last) begin
                        svc_cnt_d = '0;
                        if (length_q == 12'd0) begin
                            tail_cnt_d = '0;
                            tail_len_d = 7'd6 + {1'b0, bus.n_pad};
                            state_d    = ST_TAIL;
                        end else begin
                            psdu_cnt_d = '0;
                            state_d    = ST_PSDU;
                        end
                    end
                end

                ST_PSDU: begin
                    lfsr_d     = lfsr_step;
                    byte_asm_d = {desc_bit, byte_asm_q[7:1]};
                    if (psdu_cnt_q[2:0] == 3'd7) begin
                        byte_out_d   = byte_asm_d;
                        byte_valid_d = 1'b1;
                    end
                    psdu_cnt_d = psdu_cnt_q + 15'd1;
                    if (psdu_last) begin
                        tail_cnt_d = '0;
                        tail_len_d = 7'd6 + {1'b0, bus.n_pad};
                        state_d    = ST_TAIL;
                    end
                end

                default: begin
                    lfsr_d     = lfsr_step;
                    tail_cnt_d = tail_cnt_q + 7'd1;
                    if (tail_last) begin
                        tail_cnt_d   = '0;
                        hdr_cnt_d    = '0;
                        frame_done_d = 1'b1;
                        state_d      = ST_HEADER;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_HEADER;
            sig_q        <= '0;
            hdr_cnt_q    <= '0;
            svc_cnt_q    <= '0;
            psdu_cnt_q   <= '0;
            tail_cnt_q   <= '0;
            tail_len_q   <= '0;
            lfsr_q       <= SCR_SEED;
            byte_asm_q   <= '0;
            rate_q       <= '0;
            length_q     <= '0;
            hdr_ok_q     <= 1'b0;
            hdr_err_q    <= 1'b0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sig_q        <= sig_d;
            hdr_cnt_q    <= hdr_cnt_d;
            svc_cnt_q    <= svc_cnt_d;
            psdu_cnt_q   <= psdu_cnt_d;
            tail_cnt_q   <= tail_cnt_d;
            tail_len_q   <= tail_len_d;
            lfsr_q       <= lfsr_d;
            byte_asm_q   <= byte_asm_d;
            rate_q       <= rate_d;
            length_q     <= length_d;
            hdr_ok_q     <= hdr_ok_d;
            hdr_err_q    <= hdr_err_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.rate       = rate_q;
    assign bus.length     = length_q;
    assign bus.hdr_ok     = hdr_ok_q;
    assign bus.hdr_err    = hdr_err_q;
    assign bus.byte_out   = byte_out_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state_q != ST_HEADER);
endmodule
